// File: rtl/psubsb_seq.sv
// Sequential packed saturating subtract: four signed 4-bit lanes of a-b,
// one lane per clock, with per-lane saturation flags.
`timescale 1ns/1ps

module psubsb_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] diff,
    output logic [3:0]  ovfl
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] a_reg;
    logic [15:0] b_reg;

    logic [3:0]  nib_val [4];
    logic [3:0]  nib_ovf;
    logic [3:0]  sel_val;
    logic        sel_ovf;

    // Saturated result for every lane of the captured operands; the FSM
    // picks the lane addressed by idx each CALC cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            logic [3:0] an;
            logic [3:0] bn;
            logic [3:0] d;
            assign an = a_reg[gi*4 +: 4];
            assign bn = b_reg[gi*4 +: 4];
            assign d  = an - bn;
            // Overflow only possible when operand signs differ; it shows up
            // as a result whose sign disagrees with the minuend.
            assign nib_ovf[gi] = (an[3] != bn[3]) && (d[3] != an[3]);
            assign nib_val[gi] = nib_ovf[gi] ? (an[3] ? 4'h8 : 4'h7) : d;
        end
    endgenerate

    assign sel_val = nib_val[idx];
    assign sel_ovf = nib_ovf[idx];

    // Control FSM with registered busy/done and lane-by-lane result writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            a_reg <= 16'h0000;
            b_reg <= 16'h0000;
            diff  <= 16'h0000;
            ovfl  <= 4'h0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        diff  <= 16'h0000;
                        ovfl  <= 4'h0;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    diff[{idx, 2'b00} +: 4] <= sel_val;
                    ovfl[idx]               <= sel_ovf;
                    idx                     <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psubsb_seq.sv
// Directed self-checking bench for psubsb_seq.
`timescale 1ns/1ps

module tb_psubsb_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic [3:0]  ovfl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    psubsb_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .ovfl  (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; returns at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request for one edge (E0); returns at the negedge after E0.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
        step();
        step();
        total_cnt++;
        if ({busy, done, diff, ovfl} !== 22'h0)
            $display("FAIL reset_state got busy=%b done=%b diff=%h ovfl=%h want all 0", busy, done, diff, ovfl);
        else pass_cnt++;
        rst = 1'b0;
        step();
        $display("reset: busy=%b done=%b diff=%h ovfl=%h", busy, done, diff, ovfl);
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_k   = -1;
        start_op(16'h1234, 16'h1111);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
                total_cnt++;
                if (diff !== 16'h0123 || ovfl !== 4'h0)
                    $display("FAIL basic_result got diff=%h ovfl=%h want 0123/0", diff, ovfl);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (busy_cnt != 5) $display("FAIL basic_busy_len got %0d want 5", busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || done_k != 4)
            $display("FAIL basic_done_pulse got count=%0d at=%0d want 1 at 4", done_cnt, done_k);
        else pass_cnt++;
        total_cnt++;
        if (diff !== 16'h0123 || ovfl !== 4'h0)
            $display("FAIL basic_hold got diff=%h ovfl=%h want 0123/0", diff, ovfl);
        else pass_cnt++;
        $display("basic: a=1234 b=1111 diff=%h ovfl=%h busy_cycles=%0d", diff, ovfl, busy_cnt);
    endtask

    task automatic test_saturate();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] vd [3];
        logic [3:0]  vo [3];
        va[0] = 16'h7777; vb[0] = 16'h8888; vd[0] = 16'h7777; vo[0] = 4'hF;
        va[1] = 16'h8000; vb[1] = 16'h1000; vd[1] = 16'h8000; vo[1] = 4'b1000;
        va[2] = 16'h8F70; vb[2] = 16'h01F1; vd[2] = 16'h8E7F; vo[2] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            repeat (4) step();
            total_cnt++;
            if (done !== 1'b1 || diff !== vd[i] || ovfl !== vo[i])
                $display("FAIL sat_vec%0d got done=%b diff=%h ovfl=%b want 1/%h/%b",
                         i, done, diff, ovfl, vd[i], vo[i]);
            else pass_cnt++;
            step();
            total_cnt++;
            if (busy !== 1'b0 || done !== 1'b0 || diff !== vd[i] || ovfl !== vo[i])
                $display("FAIL sat_idle%0d got busy=%b done=%b diff=%h ovfl=%b want 0/0/%h/%b",
                         i, busy, done, diff, ovfl, vd[i], vo[i]);
            else pass_cnt++;
            $display("saturate: a=%h b=%h diff=%h ovfl=%b", va[i], vb[i], diff, ovfl);
        end
    endtask

    task automatic test_ignore_inputs();
        int done_cnt = 0;
        start_op(16'h1234, 16'h1111);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        for (int k = 1; k < 10; k++) begin
            step();
            if (k == 4) start = 1'b0;
            if (done === 1'b1) done_cnt++;
        end
        total_cnt++;
        if (done_cnt != 1) $display("FAIL ignore_done_count got %0d want 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (diff !== 16'h0123 || ovfl !== 4'h0 || busy !== 1'b0)
            $display("FAIL ignore_result got diff=%h ovfl=%h busy=%b want 0123/0/0", diff, ovfl, busy);
        else pass_cnt++;
        $display("ignore: diff=%h done_pulses=%0d", diff, done_cnt);
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        start_op(16'h1234, 16'h1111);
        step();                         // E1 has written nibble 0
        rst   = 1'b1;                   // asserted ahead of E2
        start = 1'b1;                   // reset must dominate
        #1;
        total_cnt++;
        if ({busy, done, diff, ovfl} !== 22'h0)
            $display("FAIL abort_async got busy=%b done=%b diff=%h ovfl=%h want all 0", busy, done, diff, ovfl);
        else pass_cnt++;
        step();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_dominate got busy=%b done=%b want 0/0", busy, done);
        else pass_cnt++;
        // Release reset with start already high: first edge must accept.
        rst = 1'b0; a = 16'h7777; b = 16'h8888;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL abort_restart_busy got %b want 1", busy);
        else pass_cnt++;
        for (int k = 1; k < 6; k++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        total_cnt++;
        if (done_cnt != 1 || diff !== 16'h7777 || ovfl !== 4'hF)
            $display("FAIL abort_rerun got done_cnt=%0d diff=%h ovfl=%h want 1/7777/F", done_cnt, diff, ovfl);
        else pass_cnt++;
        $display("abort: rerun diff=%h ovfl=%h", diff, ovfl);
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            total_cnt++;
            if (done !== ((k % 6) == 4) || busy !== ((k % 6) != 5))
                $display("FAIL b2b_cycle%0d got busy=%b done=%b want %b/%b",
                         k, busy, done, (k % 6) != 5, (k % 6) == 4);
            else pass_cnt++;
        end
        start = 1'b0;
        repeat (6) step();
        total_cnt++;
        if (busy !== 1'b0 || diff !== 16'h0123)
            $display("FAIL b2b_final got busy=%b diff=%h want 0/0123", busy, diff);
        else pass_cnt++;
        $display("back_to_back: done pulses in 20 cycles=%0d", done_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_ignore_inputs();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
